// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences IR/A/B/ALUOut/MDR,
// drives mux selects, write enables and ALU control. Define MC_BNE_EN to decode bne.
module mc_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

`ifdef MC_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  logic [3:0] state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       is_bne;
  logic       retire;
  logic       decode_illegal;

  assign state  = state_q;
  assign is_bne = BNE_EN && (opcode == OP_BNE);

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no state can infer a latch.
    state_d     = S_FETCH;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_RTEX : S_FETCH;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = is_bne ? S_BEQ : S_FETCH;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        if (state_q == S_ADDIEX)    state_d = S_ADDIWB;
        else if (opcode == OP_LW)   state_d = S_MEMRD;
        else                        state_d = S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero ^ is_bne;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only the write-back / final states retire; illegal decodes return to FETCH uncounted.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                   (state_q == S_BEQ)   || (state_q == S_ADDIWB) || (state_q == S_JUMP));
  assign decode_illegal = (state_q == S_DECODE) && (state_d == S_FETCH);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)         instr_count <= instr_count + CNT_W'(1);
      if (decode_illegal) illegal     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboarded random/directed bench for mc_main_ctrl: instruction-level reference model
// pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_mc_main_ctrl;

  localparam int CW = 4;

`ifdef MC_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4, MWR = 4'd5,
                         RX = 4'd6, RW = 4'd7, BQ = 4'd8, AX = 4'd9, AW = 4'd10, JP = 4'd11;

  typedef enum {C_LW, C_SW, C_R, C_BR, C_ADDI, C_J, C_ILL} cls_e;

  typedef struct packed {
    logic [3:0]    st;
    logic          mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_control;
    logic [1:0]    pc_src;
    logic          pc_en;
    logic [CW-1:0] cnt;
    logic          ill;
  } obs_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic [CW-1:0] instr_count;
  logic illegal;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .pc_en(pc_en), .state(state), .instr_count(instr_count), .illegal(illegal)
  );

  obs_t  exp_q[$];
  string name_q[$];
  string tag = "reset";
  int    n_checks = 0;
  int    n_errors = 0;
  int    m_cnt = 0;
  bit    m_ill = 1'b0;

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_valid(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return funct_valid(fn) ? C_R : C_ILL;
      6'b000100: return C_BR;
      6'b000101: return BNE_ON ? C_BR : C_ILL;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Expected datapath controls for one cycle in a given step of an instruction.
  function automatic obs_t expect_obs(input logic [3:0] st, input logic rdy);
    obs_t e;
    e = '0;
    e.st  = st;
    e.cnt = CW'(m_cnt);
    e.ill = m_ill;
    case (st)
      F:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
                e.ir_write = rdy; e.pc_en = rdy; end
      D:  begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; end
      MA, AX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      MR: begin e.mem_read = 1; e.iord = 1; end
      MW: begin e.mem_to_reg = 1; e.reg_write = 1; end
      MWR: begin e.mem_write = 1; e.iord = 1; end
      RX: begin e.alu_src_a = 1; e.alu_control = funct_alu(funct); end
      RW: begin e.reg_dst = 1; e.reg_write = 1; end
      BQ: begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01;
                e.pc_en = zero ^ (BNE_ON && opcode == 6'b000101); end
      AW: e.reg_write = 1;
      JP: begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick(input logic [3:0] st, input logic rdy, input bit ret, input bit ill,
                      input bit rst);
    mem_ready = rdy;
    reset     = rst;
    exp_q.push_back(expect_obs(st, rdy));
    name_q.push_back(tag);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0;
      m_ill = 1'b0;
    end else begin
      if (ret) m_cnt = (m_cnt + 1) % (1 << CW);
      if (ill) m_ill = 1'b1;
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fetch_wait, input int mem_wait);
    cls_e c;
    opcode = op;
    funct  = fn;
    zero   = z;
    c = classify(op, fn);
    repeat (fetch_wait) tick(F, 1'b0, 0, 0, 0);
    tick(F, 1'b1, 0, 0, 0);
    tick(D, rnd_bit(), 0, c == C_ILL, 0);
    case (c)
      C_LW: begin
        tick(MA, rnd_bit(), 0, 0, 0);
        repeat (mem_wait) tick(MR, 1'b0, 0, 0, 0);
        tick(MR, 1'b1, 0, 0, 0);
        tick(MW, rnd_bit(), 1, 0, 0);
      end
      C_SW: begin
        tick(MA, rnd_bit(), 0, 0, 0);
        repeat (mem_wait) tick(MWR, 1'b0, 0, 0, 0);
        tick(MWR, 1'b1, 1, 0, 0);
      end
      C_R: begin
        tick(RX, rnd_bit(), 0, 0, 0);
        tick(RW, rnd_bit(), 1, 0, 0);
      end
      C_BR:   tick(BQ, rnd_bit(), 1, 0, 0);
      C_ADDI: begin
        tick(AX, rnd_bit(), 0, 0, 0);
        tick(AW, rnd_bit(), 1, 0, 0);
      end
      C_J:    tick(JP, rnd_bit(), 1, 0, 0);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{state, mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_control, pc_src, pc_en, instr_count, illegal};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got st=%0d rd=%b wr=%b iord=%b irw=%b rdst=%b m2r=%b rw=%b sa=%b sb=%b alu=%b pcs=%b pce=%b cnt=%0d ill=%b ; want st=%0d rd=%b wr=%b iord=%b irw=%b rdst=%b m2r=%b rw=%b sa=%b sb=%b alu=%b pcs=%b pce=%b cnt=%0d ill=%b",
                 nm, a.st, a.mem_read, a.mem_write, a.iord, a.ir_write, a.reg_dst, a.mem_to_reg,
                 a.reg_write, a.alu_src_a, a.alu_src_b, a.alu_control, a.pc_src, a.pc_en, a.cnt, a.ill,
                 e.st, e.mem_read, e.mem_write, e.iord, e.ir_write, e.reg_dst, e.mem_to_reg,
                 e.reg_write, e.alu_src_a, e.alu_src_b, e.alu_control, e.pc_src, e.pc_en, e.cnt, e.ill);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{LW, SW, RT, BEQ, BNE, ADDI, JMP, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = LW; funct = '0;
    repeat (2) @(posedge clk);
    #1;
    tag = "lw";        run_instr(LW, 6'h00, 1'b0, 0, 0);
    tag = "sw_wait3";  run_instr(SW, 6'h00, 1'b0, 0, 3);
    tag = "r_slt";     run_instr(RT, 6'b101010, 1'b0, 1, 0);
    tag = "r_badfn";   run_instr(RT, 6'b111111, 1'b0, 0, 0);
    tag = "beq_z1";    run_instr(BEQ, 6'h00, 1'b1, 0, 0);
    tag = "beq_z0";    run_instr(BEQ, 6'h00, 1'b0, 0, 0);
    tag = "bne_z0";    run_instr(BNE, 6'h00, 1'b0, 0, 0);
    tag = "addi";      run_instr(ADDI, 6'h00, 1'b0, 2, 0);
    tag = "jump";      run_instr(JMP, 6'h00, 1'b0, 0, 0);
    tag = "lw_wait";   run_instr(LW, 6'h00, 1'b0, 1, 2);

    // Reset in the middle of a stalled load drops the access and clears count and flag.
    tag = "mid_reset";
    opcode = LW;
    tick(F, 1'b1, 0, 0, 0);
    tick(D, 1'b1, 0, 0, 0);
    tick(MA, 1'b1, 0, 0, 0);
    tick(MR, 1'b0, 0, 0, 1);
    tag = "after_reset"; run_instr(SW, 6'h00, 1'b0, 0, 0);

    tag = "random";
    for (int i = 0; i < 250; i++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
